// File: rtl/fpga_config_loader_pkg.sv
// Shared types and sizing helpers for the fabric configuration loader.
package fpga_cfg_pkg;

    // Loader sequencing states, from power-up through a completed load.
    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        PRESENT,
        STROBE,
        HOLD,
        SETTLE,
        ARM,
        DONE
    } cfgState_t;

    localparam int DEF_WORD_WIDTH    = 32;
    localparam int DEF_CFG_WIDTH     = 320;
    localparam int DEF_NUM_FRAMES    = 172;
    localparam int DEF_SETTLE_CYCLES = 10;
    localparam int DEF_ARM_CYCLES    = 10;

    // Stream beats per frame for the default geometry.
    localparam int BEATS = DEF_CFG_WIDTH / DEF_WORD_WIDTH;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cntWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Widths of beat_cnt, frame_idx and the shared delay counter at defaults.
    localparam int BEAT_CNT_W  = cntWidth(BEATS);
    localparam int FRAME_IDX_W = cntWidth(DEF_NUM_FRAMES);
    localparam int DELAY_CNT_W = cntWidth(maxOf(DEF_SETTLE_CYCLES, DEF_ARM_CYCLES));

endpackage

// File: rtl/fpga_config_loader_assembler.sv
// Collects WORD_WIDTH stream beats into one CFG_WIDTH frame, word 0 in the LSBs.
module cfg_word_assembler
    import fpga_cfg_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int CFG_WIDTH  = DEF_CFG_WIDTH
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  word_valid,
    input  logic [WORD_WIDTH-1:0] word,
    output logic                  frame_full,
    output logic [CFG_WIDTH-1:0]  frame
);

    localparam int BEATS_L = CFG_WIDTH / WORD_WIDTH;
    localparam int BW      = cntWidth(BEATS_L);

    logic [BW-1:0]        r_beatCnt;
    logic [CFG_WIDTH-1:0] r_asmBuf;

    assign frame_full = word_valid && (r_beatCnt == BW'(BEATS_L - 1));
    assign frame      = r_asmBuf;

    // Drop each accepted word into its slot and wrap the beat count at frame end.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_beatCnt <= '0;
            r_asmBuf  <= '0;
        end else if (clear) begin
            r_beatCnt <= '0;
        end else if (word_valid) begin
            for (int k = 0; k < BEATS_L; k++) begin
                if (r_beatCnt == BW'(k)) begin
                    r_asmBuf[k*WORD_WIDTH +: WORD_WIDTH] <= word;
                end
            end
            r_beatCnt <= frame_full ? '0 : r_beatCnt + 1'b1;
        end
    end

endmodule

// File: rtl/fpga_config_loader.sv
// Sequences a streamed bitstream into fabric frame writes, then enables the fabric.
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int CFG_WIDTH     = DEF_CFG_WIDTH,
    parameter int NUM_FRAMES    = DEF_NUM_FRAMES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int ARM_CYCLES    = DEF_ARM_CYCLES
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [CFG_WIDTH-1:0]  configs_in,
    output logic [NUM_FRAMES-1:0] configs_en,
    output logic                  ff_en,
    output logic                  rdy,
    output logic                  busy
);

    localparam int FIDX_W = cntWidth(NUM_FRAMES);
    localparam int DCNT_W = cntWidth(maxOf(SETTLE_CYCLES, ARM_CYCLES));

    cfgState_t            r_state;
    logic [FIDX_W-1:0]    r_frameIdx;
    logic [DCNT_W-1:0]    r_delayCnt;

    logic                  w_accept;
    logic                  w_clear;
    logic                  w_frameFull;
    logic [CFG_WIDTH-1:0]  w_frame;
    logic [NUM_FRAMES-1:0] w_oneHot;

    assign w_accept = cfg_valid && cfg_ready;
    assign w_clear  = start && ((r_state == IDLE) || (r_state == DONE));

    cfg_word_assembler #(
        .WORD_WIDTH (WORD_WIDTH),
        .CFG_WIDTH  (CFG_WIDTH)
    ) u_assembler (
        .clock      (clock),
        .rst        (rst),
        .clear      (w_clear),
        .word_valid (w_accept),
        .word       (cfg_data),
        .frame_full (w_frameFull),
        .frame      (w_frame)
    );

    // Decode the current frame index into its single write-strobe bit.
    always_comb begin
        w_oneHot             = '0;
        w_oneHot[r_frameIdx] = 1'b1;
    end

    // Main sequencer: every output is a register updated on state transitions.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_frameIdx <= '0;
            r_delayCnt <= '0;
            cfg_ready  <= 1'b0;
            configs_in <= '0;
            configs_en <= '0;
            ff_en      <= 1'b0;
            rdy        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= COLLECT;
                        r_frameIdx <= '0;
                        cfg_ready  <= 1'b1;
                        busy       <= 1'b1;
                        ff_en      <= 1'b0;
                        rdy        <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (w_frameFull) begin
                        r_state   <= PRESENT;
                        cfg_ready <= 1'b0;
                    end
                end
                PRESENT: begin
                    configs_in <= w_frame;
                    configs_en <= w_oneHot;
                    r_state    <= STROBE;
                end
                STROBE: begin
                    configs_en <= '0;
                    r_state    <= HOLD;
                end
                HOLD: begin
                    if (r_frameIdx == FIDX_W'(NUM_FRAMES - 1)) begin
                        r_state    <= SETTLE;
                        r_delayCnt <= DCNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        r_frameIdx <= r_frameIdx + 1'b1;
                        r_state    <= COLLECT;
                        cfg_ready  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (r_delayCnt == '0) begin
                        r_state    <= ARM;
                        ff_en      <= 1'b1;
                        r_delayCnt <= DCNT_W'(ARM_CYCLES - 1);
                    end else begin
                        r_delayCnt <= r_delayCnt - 1'b1;
                    end
                end
                ARM: begin
                    if (r_delayCnt == '0) begin
                        r_state <= DONE;
                        rdy     <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_delayCnt <= r_delayCnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
